// File: rtl/w_bus_arbiter.sv
// Round-robin write arbiter: merges N_REQ requesters onto one registered
// downstream write channel, with an optional abort when the slave stalls.
module w_bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_data,
  output logic                      busy,
  output logic                      err_timeout,
  output logic [IDX_W-1:0]          err_port,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      dbg_state,
  output logic [IDX_W-1:0]          dbg_rr_ptr
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high at the rising edge; ready never depends on a port's own data.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]   N_REQ_L  = (IDX_W + 1)'(N_REQ);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_to_q, err_to_d;
  logic [IDX_W-1:0]    err_port_q, err_port_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Search from rr_q upwards with an explicit modulo wrap, so that
  // non-power-of-two N_REQ never selects a nonexistent port.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W + 1)'(i);
      if (cand >= N_REQ_L) cand = cand - N_REQ_L;
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    err_to_d   = err_to_q;
    err_port_d = err_port_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          state_d   = ISSUE;
          m_valid_d = 1'b1;
          m_addr_d  = sel_addr;
          m_data_d  = sel_data;
          grant_d   = win_idx;
          rr_d      = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
          cnt_d     = '0;
        end
      end
      ISSUE: begin
        // A handshake in the abort cycle takes precedence over the timeout.
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          m_valid_d  = 1'b0;
          err_to_d   = 1'b1;
          err_port_d = grant_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      err_to_q   <= 1'b0;
      err_port_q <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      err_to_q   <= err_to_d;
      err_port_q <= err_port_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_addr      = m_addr_q;
  assign m_data      = m_data_q;
  assign busy        = (state_q == ISSUE);
  assign err_timeout = err_to_q;
  assign err_port    = err_port_q;
  assign grant_id    = grant_q;
  assign dbg_state   = state_q;
  assign dbg_rr_ptr  = rr_q;

endmodule

// File: tb/tb_w_bus_arbiter.sv
// Directed bench for w_bus_arbiter: a 4-port instance with an 8-cycle timeout
// and a 3-port instance with the timeout disabled.
module tb_w_bus_arbiter;

  logic clk;
  logic rstn;

  logic [3:0]   req_valid4, req_ready4;
  logic [31:0]  req_addr4;
  logic [127:0] req_data4;
  logic         m_valid4, m_ready4, busy4, err_timeout4, dbg_state4;
  logic [7:0]   m_addr4;
  logic [31:0]  m_data4;
  logic [1:0]   err_port4, grant_id4, dbg_rr4;

  logic [2:0]   req_valid3, req_ready3;
  logic [23:0]  req_addr3;
  logic [95:0]  req_data3;
  logic         m_valid3, m_ready3, busy3, err_timeout3, dbg_state3;
  logic [7:0]   m_addr3;
  logic [31:0]  m_data3;
  logic [1:0]   err_port3, grant_id3, dbg_rr3;

  int n_vec;
  int n_err;

  w_bus_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(8)) u_dut4 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_addr(req_addr4), .req_data(req_data4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_addr(m_addr4), .m_data(m_data4),
    .busy(busy4), .err_timeout(err_timeout4), .err_port(err_port4),
    .grant_id(grant_id4), .dbg_state(dbg_state4), .dbg_rr_ptr(dbg_rr4)
  );

  w_bus_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(0)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr3), .req_data(req_data3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_addr(m_addr3), .m_data(m_data3),
    .busy(busy3), .err_timeout(err_timeout3), .err_port(err_port3),
    .grant_id(grant_id3), .dbg_state(dbg_state3), .dbg_rr_ptr(dbg_rr3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid4 = '0; req_addr4 = '0; req_data4 = '0; m_ready4 = 1'b0;
    req_valid3 = '0; req_addr3 = '0; req_data3 = '0; m_ready3 = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic set_port4(input int p, input logic [7:0] a, input logic [31:0] d);
    req_addr4[p*8 +: 8]   = a;
    req_data4[p*32 +: 32] = d;
  endtask

  task automatic set_port3(input int p, input logic [7:0] a, input logic [31:0] d);
    req_addr3[p*8 +: 8]   = a;
    req_data3[p*32 +: 32] = d;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got=%b exp=0", m_valid4); end
    n_vec++; if (m_addr4 !== 8'h00) begin n_err++; $display("FAIL rst_m_addr got=%h exp=00", m_addr4); end
    n_vec++; if (m_data4 !== 32'h0) begin n_err++; $display("FAIL rst_m_data got=%h exp=0", m_data4); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy4); end
    n_vec++; if (err_timeout4 !== 1'b0) begin n_err++; $display("FAIL rst_err_timeout got=%b exp=0", err_timeout4); end
    n_vec++; if (err_port4 !== 2'd0) begin n_err++; $display("FAIL rst_err_port got=%0d exp=0", err_port4); end
    n_vec++; if (grant_id4 !== 2'd0) begin n_err++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id4); end
    n_vec++; if (req_ready4 !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready4); end
    n_vec++; if (dbg_state4 !== 1'b0) begin n_err++; $display("FAIL rst_state got=%b exp=0", dbg_state4); end
    n_vec++; if (dbg_rr4 !== 2'd0) begin n_err++; $display("FAIL rst_rr_ptr got=%0d exp=0", dbg_rr4); end
    step();
    n_vec++; if (dbg_state4 !== 1'b0) begin n_err++; $display("FAIL idle_stays got=%b exp=0", dbg_state4); end
  endtask

  task automatic test_single();
    m_ready4 = 1'b1;
    set_port4(2, 8'h10, 32'h0000_0003);
    req_valid4 = 4'b0100;
    #1;
    n_vec++; if (req_ready4 !== 4'b0100) begin n_err++; $display("FAIL single_req_ready got=%b exp=0100", req_ready4); end
    step();
    req_valid4 = '0;
    n_vec++; if (m_valid4 !== 1'b1) begin n_err++; $display("FAIL single_m_valid got=%b exp=1", m_valid4); end
    n_vec++; if (m_addr4 !== 8'h10) begin n_err++; $display("FAIL single_m_addr got=%h exp=10", m_addr4); end
    n_vec++; if (m_data4 !== 32'h3) begin n_err++; $display("FAIL single_m_data got=%h exp=3", m_data4); end
    n_vec++; if (grant_id4 !== 2'd2) begin n_err++; $display("FAIL single_grant_id got=%0d exp=2", grant_id4); end
    n_vec++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL single_busy_t1 got=%b exp=1", busy4); end
    step();
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL single_busy_t2 got=%b exp=0", busy4); end
    n_vec++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL single_m_valid_t2 got=%b exp=0", m_valid4); end
    n_vec++; if (dbg_rr4 !== 2'd3) begin n_err++; $display("FAIL single_rr_ptr got=%0d exp=3", dbg_rr4); end
    m_ready4 = 1'b0;
  endtask

  task automatic test_round_robin();
    int p;
    do_reset();
    m_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) set_port4(i, 8'(8'h20 + i), 32'hA000_0000 + i);
    req_valid4 = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      p = k % 4;
      n_vec++; if (req_ready4 !== 4'(1 << p)) begin n_err++; $display("FAIL rr_req_ready k=%0d got=%b exp=%b", k, req_ready4, 4'(1 << p)); end
      step();
      n_vec++; if (m_valid4 !== 1'b1) begin n_err++; $display("FAIL rr_m_valid k=%0d got=%b exp=1", k, m_valid4); end
      n_vec++; if (grant_id4 !== 2'(p)) begin n_err++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grant_id4, p); end
      n_vec++; if (m_addr4 !== 8'(8'h20 + p)) begin n_err++; $display("FAIL rr_m_addr k=%0d got=%h exp=%h", k, m_addr4, 8'(8'h20 + p)); end
      n_vec++; if (m_data4 !== 32'hA000_0000 + p) begin n_err++; $display("FAIL rr_m_data k=%0d got=%h exp=%h", k, m_data4, 32'hA000_0000 + p); end
      n_vec++; if (req_ready4 !== 4'b0000) begin n_err++; $display("FAIL rr_ready_issue k=%0d got=%b exp=0000", k, req_ready4); end
      step();
    end
    req_valid4 = '0;
    m_ready4 = 1'b0;
  endtask

  task automatic test_back_pressure();
    int hs;
    hs = 0;
    m_ready4 = 1'b0;
    set_port4(1, 8'h55, 32'hDEAD_BEEF);
    set_port4(3, 8'h77, 32'h1234_5678);
    req_valid4 = 4'b0010;
    #1;
    n_vec++; if (req_ready4 !== 4'b0010) begin n_err++; $display("FAIL bp_req_ready got=%b exp=0010", req_ready4); end
    step();
    req_valid4 = 4'b1000;
    for (int c = 1; c <= 6; c++) begin
      m_ready4 = (c == 6);
      #1;
      n_vec++; if (m_valid4 !== 1'b1) begin n_err++; $display("FAIL bp_m_valid c=%0d got=%b exp=1", c, m_valid4); end
      n_vec++; if (m_addr4 !== 8'h55) begin n_err++; $display("FAIL bp_m_addr c=%0d got=%h exp=55", c, m_addr4); end
      n_vec++; if (m_data4 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bp_m_data c=%0d got=%h exp=deadbeef", c, m_data4); end
      n_vec++; if (req_ready4 !== 4'b0000) begin n_err++; $display("FAIL bp_req_ready_hold c=%0d got=%b exp=0000", c, req_ready4); end
      if (m_valid4 === 1'b1 && m_ready4 === 1'b1) hs++;
      step();
    end
    n_vec++; if (hs !== 1) begin n_err++; $display("FAIL bp_transfers got=%0d exp=1", hs); end
    n_vec++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL bp_m_valid_done got=%b exp=0", m_valid4); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL bp_busy_done got=%b exp=0", busy4); end
    n_vec++; if (req_ready4 !== 4'b1000) begin n_err++; $display("FAIL bp_next_ready got=%b exp=1000", req_ready4); end
    n_vec++; if (err_timeout4 !== 1'b0) begin n_err++; $display("FAIL bp_no_timeout got=%b exp=0", err_timeout4); end
    req_valid4 = '0;
    m_ready4 = 1'b0;
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    m_ready4 = 1'b0;
    set_port4(1, 8'h66, 32'h0BAD_F00D);
    req_valid4 = 4'b0010;
    #1;
    n_vec++; if (req_ready4 !== 4'b0010) begin n_err++; $display("FAIL to_req_ready got=%b exp=0010", req_ready4); end
    step();
    req_valid4 = '0;
    for (int c = 1; c <= 8; c++) begin
      if (m_valid4 === 1'b1) hi++;
      if (c == 8) begin
        n_vec++; if (err_timeout4 !== 1'b0) begin n_err++; $display("FAIL to_early_err got=%b exp=0", err_timeout4); end
      end
      step();
    end
    n_vec++; if (hi !== 8) begin n_err++; $display("FAIL to_valid_cycles got=%0d exp=8", hi); end
    n_vec++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL to_m_valid_drop got=%b exp=0", m_valid4); end
    n_vec++; if (err_timeout4 !== 1'b1) begin n_err++; $display("FAIL to_err_timeout got=%b exp=1", err_timeout4); end
    n_vec++; if (err_port4 !== 2'd1) begin n_err++; $display("FAIL to_err_port got=%0d exp=1", err_port4); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL to_busy got=%b exp=0", busy4); end
    m_ready4 = 1'b1;
    set_port4(3, 8'h33, 32'h3333_0003);
    req_valid4 = 4'b1000;
    #1;
    n_vec++; if (req_ready4 !== 4'b1000) begin n_err++; $display("FAIL to_p3_ready got=%b exp=1000", req_ready4); end
    step();
    req_valid4 = '0;
    n_vec++; if (m_valid4 !== 1'b1) begin n_err++; $display("FAIL to_p3_m_valid got=%b exp=1", m_valid4); end
    n_vec++; if (grant_id4 !== 2'd3) begin n_err++; $display("FAIL to_p3_grant got=%0d exp=3", grant_id4); end
    n_vec++; if (m_data4 !== 32'h3333_0003) begin n_err++; $display("FAIL to_p3_m_data got=%h exp=33330003", m_data4); end
    step();
    n_vec++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL to_p3_done got=%b exp=0", m_valid4); end
    n_vec++; if (err_timeout4 !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b exp=1", err_timeout4); end
    n_vec++; if (err_port4 !== 2'd1) begin n_err++; $display("FAIL to_err_port_kept got=%0d exp=1", err_port4); end
    m_ready4 = 1'b0;
  endtask

  task automatic test_async_reset();
    m_ready4 = 1'b0;
    set_port4(1, 8'h44, 32'h4444_0001);
    req_valid4 = 4'b0010;
    #1;
    step();
    req_valid4 = '0;
    n_vec++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL ar_busy_pre got=%b exp=1", busy4); end
    n_vec++; if (dbg_rr4 !== 2'd2) begin n_err++; $display("FAIL ar_rr_pre got=%0d exp=2", dbg_rr4); end
    #2;
    rstn = 1'b0;
    #1;
    n_vec++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL ar_m_valid_async got=%b exp=0", m_valid4); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL ar_busy_async got=%b exp=0", busy4); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step();
    n_vec++; if (dbg_rr4 !== 2'd0) begin n_err++; $display("FAIL ar_rr_post got=%0d exp=0", dbg_rr4); end
    n_vec++; if (err_timeout4 !== 1'b0) begin n_err++; $display("FAIL ar_err_cleared got=%b exp=0", err_timeout4); end
    m_ready4 = 1'b1;
    set_port4(3, 8'h3C, 32'hC0DE_0003);
    req_valid4 = 4'b1000;
    #1;
    n_vec++; if (req_ready4 !== 4'b1000) begin n_err++; $display("FAIL ar_p3_ready got=%b exp=1000", req_ready4); end
    step();
    req_valid4 = '0;
    n_vec++; if (grant_id4 !== 2'd3) begin n_err++; $display("FAIL ar_p3_grant got=%0d exp=3", grant_id4); end
    n_vec++; if (m_addr4 !== 8'h3C) begin n_err++; $display("FAIL ar_p3_m_addr got=%h exp=3c", m_addr4); end
    n_vec++; if (dbg_rr4 !== 2'd0) begin n_err++; $display("FAIL ar_rr_wrap got=%0d exp=0", dbg_rr4); end
    step();
    m_ready4 = 1'b0;
  endtask

  task automatic test_non_pow2();
    do_reset();
    m_ready3 = 1'b1;
    set_port3(1, 8'h31, 32'h3100_0001);
    req_valid3 = 3'b010;
    #1;
    n_vec++; if (req_ready3 !== 3'b010) begin n_err++; $display("FAIL np_p1_ready got=%b exp=010", req_ready3); end
    step();
    req_valid3 = '0;
    step();
    n_vec++; if (dbg_rr3 !== 2'd2) begin n_err++; $display("FAIL np_rr_start got=%0d exp=2", dbg_rr3); end
    set_port3(0, 8'h30, 32'h3000_0000);
    set_port3(2, 8'h32, 32'h3200_0002);
    req_valid3 = 3'b101;
    #1;
    n_vec++; if (req_ready3 !== 3'b100) begin n_err++; $display("FAIL np_first_ready got=%b exp=100", req_ready3); end
    step();
    n_vec++; if (grant_id3 !== 2'd2) begin n_err++; $display("FAIL np_first_grant got=%0d exp=2", grant_id3); end
    n_vec++; if (m_addr3 !== 8'h32) begin n_err++; $display("FAIL np_first_addr got=%h exp=32", m_addr3); end
    n_vec++; if (dbg_rr3 !== 2'd0) begin n_err++; $display("FAIL np_rr_wrap got=%0d exp=0", dbg_rr3); end
    step();
    n_vec++; if (req_ready3 !== 3'b001) begin n_err++; $display("FAIL np_second_ready got=%b exp=001", req_ready3); end
    step();
    req_valid3 = '0;
    n_vec++; if (grant_id3 !== 2'd0) begin n_err++; $display("FAIL np_second_grant got=%0d exp=0", grant_id3); end
    n_vec++; if (m_data3 !== 32'h3000_0000) begin n_err++; $display("FAIL np_second_data got=%h exp=30000000", m_data3); end
    n_vec++; if (dbg_rr3 !== 2'd1) begin n_err++; $display("FAIL np_rr_after got=%0d exp=1", dbg_rr3); end
    step();
    m_ready3 = 1'b0;
    req_valid3 = 3'b010;
    #1;
    step();
    req_valid3 = '0;
    repeat (12) step();
    n_vec++; if (m_valid3 !== 1'b1) begin n_err++; $display("FAIL np_no_timeout_valid got=%b exp=1", m_valid3); end
    n_vec++; if (err_timeout3 !== 1'b0) begin n_err++; $display("FAIL np_no_timeout_err got=%b exp=0", err_timeout3); end
    m_ready3 = 1'b1;
    step();
    n_vec++; if (m_valid3 !== 1'b0) begin n_err++; $display("FAIL np_late_done got=%b exp=0", m_valid3); end
    m_ready3 = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_async_reset();
    test_non_pow2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
